// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the execute-stage sequencer. Holds the
//               sequencer state encoding, the default register index width
//               and the NOP encoding injected as an EX bubble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // Default register index width (32 architectural registers)
  localparam int PIPE_REG_AW = 5;

  // Canonical NOP (addi x0, x0, 0): write_back=0, mem_en=0, rd=0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Execute-stage sequencer states
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LD_WAIT = 2'd1,
    FLUSH   = 2'd2
  } ex_state_t;

  // Flush counter reload value, range-limited to the 3-bit counter
  function automatic logic [2:0] flush_reload(input int cycles);
    logic [2:0] v;
    v = 3'(cycles);
    return (v == 3'd0) ? 3'd1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use comparator. Flags a hazard when the
//               valid ID instruction reads a register that the load in EX is
//               about to write. x0 is never a hazard.
// Ports       : id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2 - ID operands
//               ex_rd, ex_load                                  - EX producer
//               hazard                                          - result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_load,
  output logic              hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign hazard  = id_valid && ex_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

`default_nettype wire

// File: rtl/ex_hazard_ctrl.sv
// ============================================================================
// Module      : ex_hazard_ctrl
// Description : Execute-stage sequencer. Each cycle decides whether the ID->EX
//               handoff advances, stalls on a load-use hazard (LD_WAIT until
//               mem_ready) or is squashed after a taken branch (FLUSH for
//               FLUSH_CYCLES cycles). A taken branch always wins over a stall.
// Ports       : clk, rst_n (async, active-low)
//               id_*            - ID stage operand info
//               ex_rd, ex_load  - EX stage producer info
//               mem_ready       - load data returned this cycle
//               br_valid/br_taken - registered ALU branch outcome
//               stall_if, stall_id, bubble_ex, take_branch - controls
//               stall_cnt, flush_cnt - statistics (HAZARD_STATS_EN only)
// Options     : `define HAZARD_STATS_EN adds saturating statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_AW       = PIPE_REG_AW,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_load,
  input  logic              mem_ready,
  input  logic              br_valid,
  input  logic              br_taken,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
`endif
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              take_branch
);

  localparam logic [2:0] FLUSH_LOAD = flush_reload(FLUSH_CYCLES);

  ex_state_t  state, state_nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic       hazard;
  logic       br_take;
  logic       stall;

  assign br_take = br_valid && br_taken;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_load    (ex_load),
    .hazard     (hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      fcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Outputs in LD_WAIT and FLUSH depend on the state register only; in RUN
  // the stall is raised combinationally in the same cycle the hazard appears.
  // rst_n gates the RUN path so all controls read 0 while reset is held.
  always_comb begin
    state_nxt   = state;
    fcnt_nxt    = fcnt;
    stall       = 1'b0;
    bubble_ex   = 1'b0;
    take_branch = 1'b0;
    case (state)
      RUN: begin
        stall     = rst_n && hazard && !br_take;
        bubble_ex = stall;
        if (br_take) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FLUSH_LOAD;
        end else if (hazard) begin
          state_nxt = LD_WAIT;
        end
      end
      LD_WAIT: begin
        stall     = 1'b1;
        bubble_ex = 1'b1;
        if (br_take) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FLUSH_LOAD;
        end else if (mem_ready) begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        take_branch = 1'b1;
        bubble_ex   = 1'b1;
        if (br_take) begin
          // A younger taken branch restarts the squash window
          fcnt_nxt = FLUSH_LOAD;
        end else if (fcnt <= 3'd1) begin
          state_nxt = RUN;
          fcnt_nxt  = 3'd0;
        end else begin
          fcnt_nxt = fcnt - 3'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        fcnt_nxt  = 3'd0;
      end
    endcase
  end

  assign stall_if = stall;
  assign stall_id = stall;

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating counters: stall cycles, and taken branches accepted in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (br_take && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
// ============================================================================
// Module      : tb_ex_hazard_ctrl
// Description : Self-checking bench for ex_hazard_ctrl (FLUSH_CYCLES=2).
//               Inputs change just after the falling edge and outputs are
//               sampled 1 time unit later, away from the rising edge.
// Options     : HAZARD_STATS_EN also exercises the counters with CNT_W=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_hazard_ctrl;

  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, ex_load, mem_ready;
  logic       br_valid, br_taken;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       stall_if, stall_id, bubble_ex, take_branch;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .REG_AW       (5),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_load     (ex_load),
    .mem_ready   (mem_ready),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
`ifdef HAZARD_STATS_EN
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
`endif
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .bubble_ex   (bubble_ex),
    .take_branch (take_branch)
  );

  typedef struct {
    logic       vld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       bv;
    logic       bt;
    logic       exp_stall;
  } vec_t;

  vec_t vecs [10];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic chkn(input string nm, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
`endif

  task automatic chk_out(input string nm, input logic es, input logic eb, input logic et);
    chk1({nm, ".stall_if"},    stall_if,    es);
    chk1({nm, ".stall_id"},    stall_id,    es);
    chk1({nm, ".bubble_ex"},   bubble_ex,   eb);
    chk1({nm, ".take_branch"}, take_branch, et);
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_load = 1'b0; mem_ready = 1'b0;
    br_valid = 1'b0; br_taken = 1'b0;
  endtask

  // load x5 in EX, ID add x6,x5,x1
  task automatic set_haz();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd1;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    ex_rd = 5'd5; ex_load = 1'b1;
  endtask

  task automatic set_br(input logic on);
    br_valid = on; br_taken = on;
  endtask

  // Advance to just after the next falling edge
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nxt();
    idle();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};

    idle();
    rst_n = 1'b0;
    #2;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    nxt();
    rst_n = 1'b1;

    // Combinational decisions in RUN; inputs return to idle before the
    // rising edge so the state never leaves RUN.
    for (int i = 0; i < 10; i++) begin
      nxt();
      id_valid = vecs[i].vld; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_use_rs1 = vecs[i].u1; id_use_rs2 = vecs[i].u2;
      ex_rd = vecs[i].rd; ex_load = vecs[i].ld;
      br_valid = vecs[i].bv; br_taken = vecs[i].bt;
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_stall, 1'b0);
      idle();
    end

    // Load-use with mem_ready one cycle later: two stall cycles
    nxt(); set_haz(); #1;               chk_out("ld.c0", 1'b1, 1'b1, 1'b0);
    nxt(); mem_ready = 1'b1; #1;        chk_out("ld.c1", 1'b1, 1'b1, 1'b0);
    nxt(); idle(); #1;                  chk_out("ld.c2", 1'b0, 1'b0, 1'b0);

    // Taken branch: exactly two flush cycles, hazard ignored while flushing
    nxt(); set_br(1'b1); #1;            chk_out("br.c0", 1'b0, 1'b0, 1'b0);
    nxt(); set_br(1'b0); set_haz(); #1; chk_out("br.c1", 1'b0, 1'b1, 1'b1);
    nxt(); idle(); #1;                  chk_out("br.c2", 1'b0, 1'b1, 1'b1);
    nxt(); #1;                          chk_out("br.c3", 1'b0, 1'b0, 1'b0);
    nxt(); #1;                          chk_out("br.c4", 1'b0, 1'b0, 1'b0);

    // Taken branch in the last flush cycle reloads the window
    nxt(); set_br(1'b1); #1;
    nxt(); set_br(1'b0); #1;            chk_out("rl.c1", 1'b0, 1'b1, 1'b1);
    nxt(); set_br(1'b1); #1;            chk_out("rl.c2", 1'b0, 1'b1, 1'b1);
    nxt(); set_br(1'b0); #1;            chk_out("rl.c3", 1'b0, 1'b1, 1'b1);
    nxt(); #1;                          chk_out("rl.c4", 1'b0, 1'b1, 1'b1);
    nxt(); #1;                          chk_out("rl.c5", 1'b0, 1'b0, 1'b0);

    // Long LD_WAIT, then a taken branch overrides the stall
    nxt(); set_haz(); #1;               chk_out("lw.c0", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      nxt(); #1;                        chk_out($sformatf("lw.wait%0d", i), 1'b1, 1'b1, 1'b0);
    end
    nxt(); set_br(1'b1); #1;            chk_out("lw.br", 1'b1, 1'b1, 1'b0);
    nxt(); set_br(1'b0); #1;            chk_out("lw.f1", 1'b0, 1'b1, 1'b1);
    nxt(); idle(); #1;                  chk_out("lw.f2", 1'b0, 1'b1, 1'b1);
    nxt(); #1;                          chk_out("lw.run", 1'b0, 1'b0, 1'b0);

    // Reset between edges during FLUSH
    nxt(); set_br(1'b1); #1;
    nxt(); set_br(1'b0); #1;            chk_out("rf.pre", 1'b0, 1'b1, 1'b1);
    #1; rst_n = 1'b0; #1;               chk_out("rf.rst", 1'b0, 1'b0, 1'b0);
    nxt(); rst_n = 1'b1; #1;            chk_out("rf.rel0", 1'b0, 1'b0, 1'b0);
    nxt(); #1;                          chk_out("rf.rel1", 1'b0, 1'b0, 1'b0);

    // Reset between edges during LD_WAIT with hazard inputs still present
    nxt(); set_haz(); #1;
    nxt(); #1;                          chk_out("rw.pre", 1'b1, 1'b1, 1'b0);
    #1; rst_n = 1'b0; #1;               chk_out("rw.rst", 1'b0, 1'b0, 1'b0);
    nxt(); idle(); rst_n = 1'b1; #1;    chk_out("rw.rel", 1'b0, 1'b0, 1'b0);

`ifdef HAZARD_STATS_EN
    do_reset();
    #1;
    chkn("st.rst_stall", stall_cnt, 4'd0);
    chkn("st.rst_flush", flush_cnt, 4'd0);
    set_haz(); #1;
    nxt(); #1;
    nxt(); mem_ready = 1'b1; #1;
    nxt(); idle(); #1;
    chkn("st.stall3", stall_cnt, 4'd3);
    for (int b = 0; b < 2; b++) begin
      nxt(); set_br(1'b1); #1;
      nxt(); set_br(1'b0); #1;
      nxt(); #1;
      nxt(); #1;
    end
    chkn("st.flush2", flush_cnt, 4'd2);
    chkn("st.stall_hold", stall_cnt, 4'd3);
    // Saturation
    nxt(); set_haz(); #1;
    for (int i = 0; i < 20; i++) begin
      nxt(); #1;
    end
    chkn("st.stall_sat", stall_cnt, 4'hF);
    set_br(1'b1);
    for (int i = 0; i < 20; i++) begin
      nxt(); #1;
    end
    idle();
    chkn("st.flush_sat", flush_cnt, 4'hF);
`endif

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
